instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit with a direct-mapped instruction cache of LINES x 4 words.
// Misses fill a whole line from instruction memory; redirects during a fill are deferred.
module instruction_fetch_unit #(
  parameter int unsigned LINES    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] next_pc,
  output logic        hit
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = 28 - IdxW;

  typedef enum logic [1:0] {StLookup, StFill, StUpdate} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [1:0]         beat_q, beat_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               pend_q, pend_d;
  logic [31:0]        pend_pc_q, pend_pc_d;
  logic               data_we, tag_we;

  logic [TagW-1:0]    tag_mem  [LINES];
  logic [31:0]        data_mem [LINES][4];

  logic [IdxW-1:0]    idx;
  logic [TagW-1:0]    tag;
  logic [1:0]         offset;

  assign offset = pc_q[3:2];
  assign idx    = pc_q[4 +: IdxW];
  assign tag    = pc_q[31 -: TagW];

  assign hit         = (state_q == StLookup) && valid_q[idx] && (tag_mem[idx] == tag);
  assign instruction = hit ? data_mem[idx][offset] : 32'h0;
  assign next_pc     = pc_q + 32'd4;
  // PC is frozen for the whole fill, so the request address is stable by construction.
  assign mem_req     = (state_q == StFill);
  assign mem_addr    = {pc_q[31:4], 4'b0000};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    data_we   = 1'b0;
    tag_we    = 1'b0;
    unique case (state_q)
      StLookup: begin
        if (redirect) begin
          pc_d = {redirect_pc[31:2], 2'b00};
        end else if (hit) begin
          if (!stall) pc_d = pc_q + 32'd4;
        end else begin
          // Line is being overwritten; keep it invalid until the tag lands.
          state_d      = StFill;
          beat_d       = 2'd0;
          valid_d[idx] = 1'b0;
        end
      end
      StFill: begin
        if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = {redirect_pc[31:2], 2'b00};
        end
        if (mem_valid) begin
          data_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = StUpdate;
        end
      end
      StUpdate: begin
        tag_we       = 1'b1;
        valid_d[idx] = 1'b1;
        state_d      = StLookup;
        pend_d       = 1'b0;
        if (redirect) begin
          pc_d = {redirect_pc[31:2], 2'b00};
        end else if (pend_q) begin
          pc_d = pend_pc_q;
        end
      end
      default: state_d = StLookup;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StLookup;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      beat_q    <= 2'd0;
      valid_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (data_we) data_mem[idx][beat_q] <= mem_rdata;
    if (tag_we)  tag_mem[idx]          <= tag;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: cold start, stall, redirects, conflicts, reset.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] next_pc;
  logic        hit;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_unit #(
    .LINES   (16),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .instruction(instruction),
    .next_pc    (next_pc),
    .hit        (hit)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  // Four consecutive beats starting while in FILL; ends after the beat-3 edge (UPDATE).
  task automatic fill(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_rdata = w[i];
      step();
    end
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    reset_n     = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_valid   = 1'b0;
    mem_rdata   = 32'h0;

    // Reset state
    step();
    step();
    chk1 ("rst_mem_req", mem_req, 1'b0);
    chk1 ("rst_hit", hit, 1'b0);
    chk32("rst_instr", instruction, 32'h0);
    chk32("rst_next_pc", next_pc, 32'h4);
    reset_n = 1'b1;

    // Cold start: miss, fill at 0
    step();
    chk1 ("cold_mem_req", mem_req, 1'b1);
    chk32("cold_mem_addr", mem_addr, 32'h0);
    chk1 ("cold_fill_hit", hit, 1'b0);
    fill(32'h11, 32'h22, 32'h33, 32'h44);
    chk1 ("cold_upd_req", mem_req, 1'b0);
    chk1 ("cold_upd_hit", hit, 1'b0);
    step();
    chk1 ("cold_hit0", hit, 1'b1);
    chk32("cold_instr0", instruction, 32'h11);
    chk32("cold_npc0", next_pc, 32'h4);
    step();
    chk32("seq_instr1", instruction, 32'h22);
    chk32("seq_npc1", next_pc, 32'h8);

    // Stall while hitting holds everything
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1 ("stall_hit", hit, 1'b1);
      chk32("stall_instr", instruction, 32'h22);
      chk32("stall_npc", next_pc, 32'h8);
    end
    stall = 1'b0;
    step();
    chk32("post_stall_instr", instruction, 32'h33);

    // Redirect overrides stall; low bits of target ignored
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0006;
    step();
    stall    = 1'b0;
    redirect = 1'b0;
    chk32("redir_stall_instr", instruction, 32'h22);
    chk32("redir_stall_npc", next_pc, 32'h8);
    step();
    step();
    chk32("seq_instr3", instruction, 32'h44);
    chk32("seq_npc3", next_pc, 32'h10);

    // Running off the line end misses at 0x10
    step();
    chk1 ("line_end_hit", hit, 1'b0);
    chk32("line_end_instr", instruction, 32'h0);
    step();
    chk1 ("line1_req", mem_req, 1'b1);
    chk32("line1_addr", mem_addr, 32'h10);
    fill(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    step();
    chk32("line1_instr", instruction, 32'hA0);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    chk1 ("refetch0_hit", hit, 1'b1);
    chk32("refetch0_instr", instruction, 32'h11);
    chk1 ("refetch0_req", mem_req, 1'b0);

    // Conflict: 0x100 shares index 0 with 0x0
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk1 ("conf100_miss", hit, 1'b0);
    step();
    chk32("conf100_addr", mem_addr, 32'h100);
    fill(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    step();
    chk32("conf100_instr", instruction, 32'hB0);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    chk1 ("conf0_miss", hit, 1'b0);
    step();
    chk32("conf0_addr", mem_addr, 32'h0);

    // Redirects during fill are deferred; the later one wins
    mem_valid   = 1'b1;
    mem_rdata   = 32'h11;
    redirect    = 1'b1;
    redirect_pc = 32'h204;
    step();
    mem_rdata = 32'h22;
    redirect  = 1'b0;
    step();
    mem_rdata   = 32'h33;
    redirect    = 1'b1;
    redirect_pc = 32'h104;
    step();
    redirect = 1'b0;
    chk1 ("pend_req_held", mem_req, 1'b1);
    chk32("pend_addr_held", mem_addr, 32'h0);
    mem_rdata = 32'h44;
    step();
    mem_valid = 1'b0;
    chk1 ("pend_upd_req", mem_req, 1'b0);
    step();
    chk1 ("pend_miss", hit, 1'b0);
    chk32("pend_npc", next_pc, 32'h108);
    step();
    chk32("pend_fill_addr", mem_addr, 32'h100);
    fill(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    step();
    chk1 ("pend_hit", hit, 1'b1);
    chk32("pend_instr", instruction, 32'hB1);

    // Wrap of next_pc, then reset mid-fill
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk32("wrap_npc", next_pc, 32'h0);
    step();
    chk32("wrap_fill_addr", mem_addr, 32'hFFFF_FFF0);
    mem_valid = 1'b1;
    mem_rdata = 32'hC0;
    step();
    mem_rdata = 32'hC1;
    step();
    mem_rdata = 32'hC2;
    step();
    mem_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk1 ("midrst_req", mem_req, 1'b0);
    chk32("midrst_npc", next_pc, 32'h4);
    #1;
    reset_n = 1'b1;
    chk1 ("midrst_hit", hit, 1'b0);
    step();
    chk1 ("midrst_refill_req", mem_req, 1'b1);
    chk32("midrst_refill_addr", mem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
